// File: rtl/regfile_core_pkg.sv
// Shared sizing constants for the register file, its read muxes and the datapath.
package regfile_core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;

endpackage

// File: rtl/regfile_core_mux32to1by32.sv
// 32-input, 32-bit-wide combinational selector used by each register-file read port.
module mux32to1by32
  import regfile_core_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] address,
  input  logic [REG_DATA_W-1:0] inputs [REG_COUNT],
  output logic [REG_DATA_W-1:0] out
);

  assign out = inputs[address];

endmodule

// File: rtl/regfile_core_register32.sv
// One 32-bit storage register with write enable and asynchronous active-low clear.
module register32
  import regfile_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [REG_DATA_W-1:0] d,
  output logic [REG_DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_core.sv
// Register file: 31 writable registers plus a hardwired-zero r0, one write port,
// two combinational read ports with an optional same-cycle write bypass.
module regfile_core
  import regfile_core_pkg::*;
#(
  parameter bit BYPASS = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] WriteRegister,
  input  logic [REG_DATA_W-1:0] WriteData,
  input  logic [REG_ADDR_W-1:0] ReadRegister1,
  input  logic [REG_ADDR_W-1:0] ReadRegister2,
  output logic [REG_DATA_W-1:0] ReadData1,
  output logic [REG_DATA_W-1:0] ReadData2
);

  logic [REG_COUNT-1:1] wr_en;
  logic [REG_DATA_W-1:0] regs [REG_COUNT];
  logic [REG_DATA_W-1:0] mux_out1;
  logic [REG_DATA_W-1:0] mux_out2;
  logic                  byp1;
  logic                  byp2;

  // One-hot decode; dropping bit 0 of the shifted word means index 0 never enables anything.
  assign wr_en = RegWrite ? (REG_COUNT-1)'((REG_COUNT'(1) << WriteRegister) >> 1) : '0;

  assign regs[0] = '0;

  for (genvar k = 1; k < REG_COUNT; k++) begin : g_reg
    register32 u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wr_en[k]),
      .d     (WriteData),
      .q     (regs[k])
    );
  end

  mux32to1by32 u_mux1 (
    .address (ReadRegister1),
    .inputs  (regs),
    .out     (mux_out1)
  );

  mux32to1by32 u_mux2 (
    .address (ReadRegister2),
    .inputs  (regs),
    .out     (mux_out2)
  );

  // Forward the in-flight write only for nonzero indices so r0 stays zero under bypass.
  assign byp1 = BYPASS && RegWrite && (WriteRegister != '0) && (ReadRegister1 == WriteRegister);
  assign byp2 = BYPASS && RegWrite && (WriteRegister != '0) && (ReadRegister2 == WriteRegister);

  assign ReadData1 = byp1 ? WriteData : mux_out1;
  assign ReadData2 = byp2 ? WriteData : mux_out2;

endmodule

// File: doc/regfile_core.md
# regfile_core

Thirty-two-entry, 32-bit register file storage with one write port and two read ports. Owns the register array, the write-address decoder and register-zero handling. Each read port drives one `mux32to1by32` whose 32 inputs are the stored registers. This block is the stage directly upstream of those muxes and supplies every `inputs[j]` word they select from.

## Interface
Parameters:
- `BYPASS`, default 0: when 1, a read of the register being written in the same cycle returns `WriteData` instead of the stored value.

Ports:
- `clk`  input  1  single clock; all storage updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low; clears every register.
- `RegWrite`  input  1  write enable for the current cycle.
- `WriteRegister`  input  5  destination register index.
- `WriteData`  input  32  value to store.
- `ReadRegister1`  input  5  read port 1 index.
- `ReadRegister2`  input  5  read port 2 index.
- `ReadData1`  output  32  contents of `ReadRegister1`.
- `ReadData2`  output  32  contents of `ReadRegister2`.

## Operation
- Storage consists of 32 registers, r0 to r31, each 32 bits wide.
- **r0** is hardwired to 0.
  - Writes to index 0 are discarded.
  - r0 reads 0 always, including under `BYPASS`.
- **Write decode.** A 5-to-32 one-hot decoder, gated by `RegWrite`, produces per-register enables. At most one enable is active per cycle, and it is never the enable for r0.
- **Write.** On a rising edge of `clk` with `RegWrite`=1 and `WriteRegister`=k≠0, rk takes `WriteData`. All other registers hold their values.
- `RegWrite`=0 leaves every register unchanged, whatever the address and data inputs are.
- **Read.** Each read port connects all 32 register outputs to a `mux32to1by32` instance, with the port's index as the address. Reads are combinational.
- **Same-register read on both ports.** If both read ports address the same register, both outputs carry the same value.
- **Bypass.** With `BYPASS`=1, `RegWrite`=1, `ReadRegisterN`=`WriteRegister`≠0: `ReadDataN`=`WriteData` in the same cycle.
- **No bypass.** With `BYPASS`=0, the read in that case returns the old value until the edge.
- **Widths.** No arithmetic is performed. Indices are 5-bit unsigned and cover all 32 registers, so there is no out-of-range case.

## Timing
- **Reset.**
  - While `rst_n`=0, all registers are 0, independent of `clk`.
  - Hence `ReadData1`=`ReadData2`=0 during reset for every index.
  - Reset asserted mid-write wins: the register is 0 afterwards.
- **Reset release.** Writes resume on the first rising edge that sees `rst_n`=1.
- **Write latency.** A write presented before edge N is visible on both read ports immediately after edge N, combinationally.
- **Read latency.** Read latency is 0 cycles from an index change to the data change. The combinational path runs through the decoder-free mux only.
- **Back-to-back writes.** Consecutive cycles may write the same or different registers. The last write to a register wins.
- **Simultaneous read and write (`BYPASS`=0).**
  - During cycle N the read returns the pre-edge value.
  - From edge N onward it returns the new value.

## Structure
- **Shared package** holds `REG_ADDR_W`=5, `REG_DATA_W`=32 and `REG_COUNT`=32. The same package is used by `mux32to1by32` and the datapath.
- **Sub-module `register32`:** a 32-bit flop with enable and asynchronous active-low clear.
  - The top level instantiates it 31 times, for r1 to r31.
  - r0 is a constant 0 driven onto mux input 0.
- **Decoder:** the 5-to-32 decoder stays inline as a shifted-enable expression.
- **Read muxes:** two `mux32to1by32` instances.

## Test plan
- **Reset:** hold `rst_n`=0 and sweep both read indices 0 to 31 -> all reads are 0. Preload r5=0xDEADBEEF, then assert `rst_n`=0 asynchronously between edges -> r5 reads 0 at once, before any edge.
- **Write/read all:** write rk=k×0x01010101 for k=1 to 31, then read each on both ports -> the exact pattern is returned. Read r0 -> 0.
- **r0 protection:** `RegWrite`=1, `WriteRegister`=0, `WriteData`=0xFFFFFFFF -> r0 reads 0 and no other register changes.
- **Write disable:** r7=0x12345678, then `RegWrite`=0, `WriteRegister`=7, `WriteData`=0xAAAAAAAA for 3 edges -> r7 still reads 0x12345678.
- **Same-cycle read/write, `BYPASS`=0:** r9=0x1, then write r9=0x2 while reading r9 -> 0x1 before the edge, 0x2 after.
- **Same-cycle read/write, `BYPASS`=1:** the same stimulus -> 0x2 before the edge. A bypass on index 0 -> 0.
